// File: rtl/vga_timing_pkg.sv
// VGA timing defaults (640x480@60) and the helper that sums an axis into its total.
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_HSYNC_POL = 1'b0;
  localparam bit DEF_VSYNC_POL = 1'b0;
  localparam int DEF_CW        = 10;

  function automatic int axis_total(int vis, int fr, int sy, int bk);
    return vis + fr + sy + bk;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/visible decode taken from the next count,
// so a register fed by these outputs lines up exactly with the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_step,
  output logic [CW-1:0] o_nxt,
  output logic          o_wrap,
  output logic          o_sync,
  output logic          o_vis
);
  localparam int            TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_LO = CW'(VISIBLE + FRONT);
  localparam logic [CW-1:0] SYNC_HI = CW'(VISIBLE + FRONT + SYNC);
  localparam logic [CW-1:0] VIS_END = CW'(VISIBLE);

  logic [CW-1:0] r_cnt;
  logic          w_last;
  logic          w_in_sync;

  assign w_last = (r_cnt == LAST);
  assign o_wrap = i_step && w_last;

  // Wrap by explicit compare; the count never reaches 2^CW.
  always_comb begin
    o_nxt = r_cnt;
    if (i_step) o_nxt = w_last ? '0 : r_cnt + 1'b1;
  end

  assign w_in_sync = (o_nxt >= SYNC_LO) && (o_nxt < SYNC_HI);
  assign o_sync    = w_in_sync ? POL : ~POL;
  assign o_vis     = (o_nxt < VIS_END);

  // Parks on the last count so the first step lands on 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_cnt <= LAST;
    else       r_cnt <= o_nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal axis stepped by pix_en, vertical axis stepped by the
// horizontal wrap; all outputs registered on the same edge as the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = DEF_HSYNC_POL,
  parameter bit VSYNC_POL = DEF_VSYNC_POL,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  logic [CW-1:0] w_h_nxt, w_v_nxt;
  logic          w_h_wrap, w_v_wrap;
  logic          w_h_sync, w_v_sync;
  logic          w_h_vis, w_v_vis;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HSYNC_POL), .CW(CW)
  ) u_h (
    .clk(clk), .nrst(nrst), .i_step(pix_en),
    .o_nxt(w_h_nxt), .o_wrap(w_h_wrap), .o_sync(w_h_sync), .o_vis(w_h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VSYNC_POL), .CW(CW)
  ) u_v (
    .clk(clk), .nrst(nrst), .i_step(w_h_wrap),
    .o_nxt(w_v_nxt), .o_wrap(w_v_wrap), .o_sync(w_v_sync), .o_vis(w_v_vis)
  );

  // Levels only move on pix_en so that x/y read 0 (not the parked count) until the first pixel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= w_h_wrap;
      frame_start <= w_h_wrap && w_v_wrap;
      if (pix_en) begin
        hsync  <= w_h_sync;
        vsync  <= w_v_sync;
        active <= w_h_vis && w_v_vis;
        x      <= w_h_nxt;
        y      <= w_v_nxt;
      end
    end
  end
endmodule
